// File: rtl/pipeline_fetch.sv
// Instruction fetch stage: sequences the PC, issues 1-cycle-latency memory reads,
// buffers returned words in a small prefetch FIFO and hands them to the decoder.
module pipeline_fetch #(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [7:0]  RESET_PC   = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_rd,
  output logic [7:0]  mem_addr,
  input  logic [15:0] mem_rdata,
  output logic [15:0] IR_out,
  output logic [7:0]  PC_out,
  output logic        valid_out,
  input  logic        ready_in,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  output logic        halted
);

  localparam logic [3:0] DEPTH_LIMIT = 4'(FIFO_DEPTH);

  // HALT opcode lives in the top three bits of the instruction word.
  function automatic logic is_halt(input logic [15:0] word);
    return (word[15:13] == 3'b111);
  endfunction

  logic [7:0]  fetch_pc_r;
  logic        inflight_r;
  logic [7:0]  inflight_pc_r;
  logic [2:0]  count_r;
  logic        halted_r;
  logic [23:0] fifo_r [FIFO_DEPTH];

  logic        pop_s;
  logic        push_s;
  logic        issue_s;
  logic [3:0]  occupancy_s;
  logic [2:0]  wr_idx_s;

  // Handshake, issue decision and FIFO write slot.
  always_comb begin
    pop_s       = 1'b0;
    push_s      = 1'b0;
    issue_s     = 1'b0;
    occupancy_s = 4'h0;
    wr_idx_s    = 3'b000;
    pop_s       = (count_r != 3'b000) && ready_in;
    push_s      = inflight_r && !halted_r;
    occupancy_s = {1'b0, count_r} + {3'b000, inflight_r} - {3'b000, pop_s};
    if (!reset && !redirect && !halted_r && (occupancy_s < DEPTH_LIMIT)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
    wr_idx_s = count_r - {2'b00, pop_s};
  end

  // Control state: PC sequencing, in-flight tracking, occupancy and halt flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= 8'h00;
      count_r       <= 3'b000;
      halted_r      <= 1'b0;
    end else if (redirect) begin
      fetch_pc_r    <= redirect_pc;
      inflight_r    <= 1'b0;
      count_r       <= 3'b000;
      halted_r      <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        inflight_pc_r <= fetch_pc_r;
        fetch_pc_r    <= fetch_pc_r + 8'h01;
      end
      count_r <= count_r + {2'b00, push_s} - {2'b00, pop_s};
      if (push_s && is_halt(mem_rdata)) begin
        halted_r <= 1'b1;
      end
    end
  end

  // Shifting FIFO storage; entry 0 is always the head. A push into the slot
  // vacated by a simultaneous pop overrides the shift because it is assigned last.
  always_ff @(posedge clk) begin
    if (!reset && !redirect) begin
      if (pop_s) begin
        for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
          fifo_r[i] <= fifo_r[i+1];
        end
      end
      if (push_s) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          if (3'(i) == wr_idx_s) begin
            fifo_r[i] <= {mem_rdata, inflight_pc_r};
          end
        end
      end
    end
  end

  // Output presentation; invalid slots read as NOP at address zero.
  always_comb begin
    valid_out = 1'b0;
    IR_out    = 16'h0000;
    PC_out    = 8'h00;
    valid_out = (count_r != 3'b000);
    if (valid_out) begin
      IR_out = fifo_r[0][23:8];
      PC_out = fifo_r[0][7:0];
    end else begin
      IR_out = 16'h0000;
      PC_out = 8'h00;
    end
    mem_rd   = issue_s;
    mem_addr = fetch_pc_r;
    halted   = halted_r;
  end

endmodule

// File: tb/tb_pipeline_fetch.sv
// Directed bench for pipeline_fetch: streaming, stall, HALT, redirect, PC wrap, mid-stream reset.
module tb_pipeline_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_rd, mem_rd_b;
  logic [7:0]  mem_addr, mem_addr_b;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] mem_rdata_b = 16'h0000;
  logic [15:0] ir_out, ir_out_b;
  logic [7:0]  pc_out, pc_out_b;
  logic        valid_out, valid_out_b;
  logic        ready_in;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        halted, halted_b;
  logic [15:0] imem [256];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_fetch #(.FIFO_DEPTH(2), .RESET_PC(8'h00)) u_dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .IR_out(ir_out), .PC_out(pc_out), .valid_out(valid_out), .ready_in(ready_in),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
  );

  pipeline_fetch #(.FIFO_DEPTH(2), .RESET_PC(8'hFE)) u_dut_fe (
    .clk(clk), .reset(reset), .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
    .IR_out(ir_out_b), .PC_out(pc_out_b), .valid_out(valid_out_b), .ready_in(1'b1),
    .redirect(1'b0), .redirect_pc(8'h00), .halted(halted_b)
  );

  // One-cycle-latency instruction memory for each instance.
  always @(posedge clk) begin
    mem_rdata   <= mem_rd   ? imem[mem_addr]   : 16'h0000;
    mem_rdata_b <= mem_rd_b ? imem[mem_addr_b] : 16'h0000;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_head(input string tag, input logic v, input logic [7:0] pc, input logic [15:0] ir);
    check_eq({tag, ".valid"}, 32'(valid_out), 32'(v));
    check_eq({tag, ".pc"},    32'(pc_out),    32'(pc));
    check_eq({tag, ".ir"},    32'(ir_out),    32'(ir));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 16'(i);
    imem[5] = 16'hE000;
    reset = 1'b1; ready_in = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    next_cycle(); next_cycle();
    check_head("rst", 1'b0, 8'h00, 16'h0000);
    check_eq("rst.halted", 32'(halted), 32'h0);
    check_eq("rst.mem_rd", 32'(mem_rd), 32'h0);

    // Streaming from RESET_PC
    reset = 1'b0; ready_in = 1'b1; #1;
    check_eq("c0.mem_rd", 32'(mem_rd), 32'h1);
    check_eq("c0.addr", 32'(mem_addr), 32'h00);
    check_eq("c0.addr_fe", 32'(mem_addr_b), 32'hFE);
    next_cycle();
    check_eq("c1.addr", 32'(mem_addr), 32'h01);
    check_eq("c1.valid", 32'(valid_out), 32'h0);
    next_cycle();
    check_head("c2", 1'b1, 8'h00, 16'h0000);
    check_eq("c2.pc_fe", 32'(pc_out_b), 32'hFE);
    check_eq("c2.ir_fe", 32'(ir_out_b), 32'h00FE);
    next_cycle();
    check_head("c3", 1'b1, 8'h01, 16'h0001);
    check_eq("c3.pc_fe", 32'(pc_out_b), 32'hFF);

    // Stall for five cycles
    next_cycle();
    ready_in = 1'b0; #1;
    check_eq("c4.pc_fe", 32'(pc_out_b), 32'h00);
    for (int k = 0; k < 5; k++) begin
      if (k != 0) next_cycle();
      check_head("stall", 1'b1, 8'h02, 16'h0002);
      check_eq("stall.mem_rd", 32'(mem_rd), 32'h0);
      if (k == 1) check_eq("c5.pc_fe", 32'(pc_out_b), 32'h01);
    end
    next_cycle();
    ready_in = 1'b1; #1;
    check_head("c9", 1'b1, 8'h02, 16'h0002);
    check_eq("c9.mem_rd", 32'(mem_rd), 32'h1);
    check_eq("c9.addr", 32'(mem_addr), 32'h04);
    next_cycle();
    check_head("c10", 1'b1, 8'h03, 16'h0003);
    next_cycle();
    check_head("c11", 1'b1, 8'h04, 16'h0004);

    // HALT word at 05
    next_cycle();
    check_head("c12", 1'b1, 8'h05, 16'hE000);
    check_eq("c12.halted", 32'(halted), 32'h1);
    check_eq("c12.mem_rd", 32'(mem_rd), 32'h0);
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      check_head("halt", 1'b0, 8'h00, 16'h0000);
      check_eq("halt.mem_rd", 32'(mem_rd), 32'h0);
      check_eq("halt.halted", 32'(halted), 32'h1);
    end

    // Redirect out of HALT to 8'h10
    next_cycle();
    redirect = 1'b1; redirect_pc = 8'h10; #1;
    check_eq("t.mem_rd", 32'(mem_rd), 32'h0);
    next_cycle();
    redirect = 1'b0; #1;
    check_eq("t1.halted", 32'(halted), 32'h0);
    check_eq("t1.mem_rd", 32'(mem_rd), 32'h1);
    check_eq("t1.addr", 32'(mem_addr), 32'h10);
    check_eq("t1.valid", 32'(valid_out), 32'h0);
    next_cycle();
    check_eq("t2.valid", 32'(valid_out), 32'h0);
    check_eq("t2.addr", 32'(mem_addr), 32'h11);
    next_cycle();
    check_head("t3", 1'b1, 8'h10, 16'h0010);
    next_cycle();
    check_head("t4", 1'b1, 8'h11, 16'h0011);

    // Redirect to 8'h40 with a buffered head and a read in flight
    next_cycle();
    check_head("r0", 1'b1, 8'h12, 16'h0012);
    redirect = 1'b1; redirect_pc = 8'h40; #1;
    check_eq("r0.mem_rd", 32'(mem_rd), 32'h0);
    next_cycle();
    redirect = 1'b0; #1;
    check_eq("r1.valid", 32'(valid_out), 32'h0);
    check_eq("r1.addr", 32'(mem_addr), 32'h40);
    check_eq("r1.mem_rd", 32'(mem_rd), 32'h1);
    next_cycle();
    check_eq("r2.valid", 32'(valid_out), 32'h0);
    check_eq("r2.addr", 32'(mem_addr), 32'h41);
    next_cycle();
    check_head("r3", 1'b1, 8'h40, 16'h0040);
    next_cycle();
    check_head("r4", 1'b1, 8'h41, 16'h0041);

    // Fill the FIFO, then reset mid-stream
    next_cycle();
    ready_in = 1'b0; #1;
    check_head("r5", 1'b1, 8'h42, 16'h0042);
    check_eq("r5.mem_rd", 32'(mem_rd), 32'h0);
    next_cycle();
    check_head("r6", 1'b1, 8'h42, 16'h0042);
    reset = 1'b1; #1;
    check_eq("r6.mem_rd", 32'(mem_rd), 32'h0);
    next_cycle();
    reset = 1'b0; ready_in = 1'b1; #1;
    check_head("x0", 1'b0, 8'h00, 16'h0000);
    check_eq("x0.mem_rd", 32'(mem_rd), 32'h1);
    check_eq("x0.addr", 32'(mem_addr), 32'h00);
    check_eq("x0.addr_fe", 32'(mem_addr_b), 32'hFE);
    next_cycle();
    check_eq("x1.addr", 32'(mem_addr), 32'h01);
    next_cycle();
    check_head("x2", 1'b1, 8'h00, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
